// File: rtl/shift_l_pipe.sv
// Pipelined left shifter: one register stage per shift-amount bit, with
// valid/ready handshake, whole-pipeline stall and a sticky overflow flag.
module shift_l_pipe #(
  parameter int width_a = 8,
  parameter int signd_a = 1,
  parameter int width_s = 3,
  parameter int width_z = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [width_a-1:0] a_dat,
  input  logic [width_s-1:0] s_dat,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic [width_z-1:0] z_dat,
  output logic               ovf,
  output logic               out_vld,
  input  logic               out_rdy
);

  logic               stall_s;
  logic               adv_s;
  logic [width_z-1:0] ext_s;

  logic [width_z-1:0] data_r    [width_s];
  logic [width_s-1:0] sh_r      [width_s];
  logic [width_s-1:0] vld_r;
  logic [width_s-1:0] ovf_r;

  logic [width_z-1:0] src_d_s   [width_s];
  logic [width_s-1:0] src_sh_s  [width_s];
  logic [width_s-1:0] src_v_s;
  logic [width_s-1:0] src_o_s;
  logic [width_z-1:0] data_nx_s [width_s];
  logic [width_s-1:0] sh_nx_s   [width_s];
  logic [width_s-1:0] vld_nx_s;
  logic [width_s-1:0] ovf_nx_s;

  // True when x * 2^m does not fit in width_z bits of the configured signedness.
  function automatic logic shl_ovf(input logic [width_z-1:0] x, input int m);
    logic o;
    o = 1'b0;
    if (m >= width_z) begin
      o = |x;
    end else begin
      for (int i = 0; i < width_z; i++) begin
        if (signd_a != 0) begin
          o = o | ((i >= width_z - 1 - m) && (x[i] != x[width_z-1]));
        end else begin
          o = o | ((i >= width_z - m) && x[i]);
        end
      end
    end
    return o;
  endfunction

  assign stall_s = vld_r[width_s-1] & ~out_rdy;
  assign adv_s   = ~stall_s;
  assign in_rdy  = rst | ~stall_s;

  assign z_dat   = data_r[width_s-1];
  assign ovf     = ovf_r[width_s-1];
  assign out_vld = vld_r[width_s-1];

  // Operand extension to the result width.
  always_comb begin
    if (signd_a != 0) begin
      ext_s = width_z'($signed(a_dat));
    end else begin
      ext_s = width_z'(a_dat);
    end
  end

  // Stage inputs: stage 0 is fed from the ports, the rest from the previous stage.
  always_comb begin
    src_d_s[0]  = ext_s;
    src_sh_s[0] = s_dat;
    src_v_s[0]  = in_vld;
    src_o_s[0]  = 1'b0;
    for (int k = 1; k < width_s; k++) begin
      src_d_s[k]  = data_r[k-1];
      src_sh_s[k] = sh_r[k-1];
      src_v_s[k]  = vld_r[k-1];
      src_o_s[k]  = ovf_r[k-1];
    end
  end

  // Stage k conditionally shifts by 2^k and accumulates overflow.
  always_comb begin
    for (int k = 0; k < width_s; k++) begin
      sh_nx_s[k]  = src_sh_s[k];
      vld_nx_s[k] = src_v_s[k];
      if (src_sh_s[k][k]) begin
        data_nx_s[k] = src_d_s[k] << (1 << k);
        ovf_nx_s[k]  = src_o_s[k] | shl_ovf(src_d_s[k], 1 << k);
      end else begin
        data_nx_s[k] = src_d_s[k];
        ovf_nx_s[k]  = src_o_s[k];
      end
    end
  end

  // Pipeline registers: reset wins, otherwise the whole pipe advances or holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {width_s{1'b0}};
      ovf_r <= {width_s{1'b0}};
      for (int k = 0; k < width_s; k++) begin
        data_r[k] <= {width_z{1'b0}};
        sh_r[k]   <= {width_s{1'b0}};
      end
    end else if (adv_s) begin
      vld_r <= vld_nx_s;
      ovf_r <= ovf_nx_s;
      for (int k = 0; k < width_s; k++) begin
        data_r[k] <= data_nx_s[k];
        sh_r[k]   <= sh_nx_s[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_l_pipe.sv
// Directed bench for shift_l_pipe: a signed and an unsigned instance share
// stimulus; each task checks its own scenario against hand-computed values.
module tb_shift_l_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_dat;
  logic [2:0]  s_dat;
  logic        in_vld;
  logic        out_rdy;
  logic        in_rdy,   out_vld,   ovf;
  logic [11:0] z_dat;
  logic        in_rdy_u, out_vld_u, ovf_u;
  logic [11:0] z_dat_u;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_l_pipe #(.width_a(8), .signd_a(1), .width_s(3), .width_z(12)) u_dut (
    .clk(clk), .rst(rst), .a_dat(a_dat), .s_dat(s_dat), .in_vld(in_vld),
    .in_rdy(in_rdy), .z_dat(z_dat), .ovf(ovf), .out_vld(out_vld), .out_rdy(out_rdy)
  );

  shift_l_pipe #(.width_a(8), .signd_a(0), .width_s(3), .width_z(12)) u_dut_u (
    .clk(clk), .rst(rst), .a_dat(a_dat), .s_dat(s_dat), .in_vld(in_vld),
    .in_rdy(in_rdy_u), .z_dat(z_dat_u), .ovf(ovf_u), .out_vld(out_vld_u), .out_rdy(out_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; a_dat = 8'h00; s_dat = 3'd0; out_rdy = 1'b0;
    tick();
    tick();
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%0b exp=1", in_rdy); end
    rst = 1'b0; out_rdy = 1'b1;
    #1;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%0b exp=0", out_vld); end
    checks++; if (z_dat !== 12'h000) begin failures++; $display("FAIL reset_z got=%0h exp=0", z_dat); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (out_vld_u !== 1'b0) begin failures++; $display("FAIL reset_out_vld_u got=%0b exp=0", out_vld_u); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy_idle got=%0b exp=1", in_rdy); end
  endtask

  task automatic test_single();
    a_dat = 8'h81; s_dat = 3'd3; in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL single_c1_vld got=%0b exp=0", out_vld); end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL single_c2_vld got=%0b exp=0", out_vld); end
    tick();
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL single_c3_vld got=%0b exp=1", out_vld); end
    checks++; if (z_dat !== 12'hC08) begin failures++; $display("FAIL single_z got=%0h exp=c08", z_dat); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL single_ovf got=%0b exp=0", ovf); end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL single_drain_vld got=%0b exp=0", out_vld); end
  endtask

  task automatic test_overflow();
    logic [7:0]  va [5] = '{8'h7F, 8'h81, 8'h40, 8'hFF, 8'h00};
    logic [2:0]  vs [5] = '{3'd7, 3'd0, 3'd5, 3'd7, 3'd7};
    logic [11:0] vz [5] = '{12'hF80, 12'hF81, 12'h800, 12'hF80, 12'h000};
    logic        vo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_dat = va[i]; s_dat = vs[i]; in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      tick();
      tick();
      checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL ovf_vec%0d_vld got=%0b exp=1", i, out_vld); end
      checks++; if (z_dat !== vz[i]) begin failures++; $display("FAIL ovf_vec%0d_z got=%0h exp=%0h", i, z_dat, vz[i]); end
      checks++; if (ovf !== vo[i]) begin failures++; $display("FAIL ovf_vec%0d_ovf got=%0b exp=%0b", i, ovf, vo[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] ez;
    out_rdy = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      if (t <= 8) begin
        a_dat = 8'h01; s_dat = 3'(t - 1); in_vld = 1'b1;
      end else begin
        in_vld = 1'b0;
      end
      tick();
      if (t >= 3 && t <= 10) begin
        ez = 12'h001 << (t - 3);
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL stream_t%0d_vld got=%0b exp=1", t, out_vld); end
        checks++; if (z_dat !== ez) begin failures++; $display("FAIL stream_t%0d_z got=%0h exp=%0h", t, z_dat, ez); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL stream_t%0d_ovf got=%0b exp=0", t, ovf); end
      end else begin
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL stream_t%0d_idle got=%0b exp=0", t, out_vld); end
      end
    end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_dat = 8'(i); s_dat = 3'd1; in_vld = 1'b1;
      tick();
    end
    // Stall with a competing input that must be ignored.
    a_dat = 8'h55; s_dat = 3'd0; in_vld = 1'b1; out_rdy = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy got=%0b exp=0", in_rdy); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_vld got=%0b exp=1", c, out_vld); end
      checks++; if (z_dat !== 12'h002) begin failures++; $display("FAIL bp_hold%0d_z got=%0h exp=2", c, z_dat); end
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_hold%0d_rdy got=%0b exp=0", c, in_rdy); end
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      tick();
      checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL bp_item%0d_vld got=%0b exp=1", i, out_vld); end
      checks++; if (z_dat !== 12'(2 * i)) begin failures++; $display("FAIL bp_item%0d_z got=%0h exp=%0h", i, z_dat, 2 * i); end
    end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", out_vld); end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%0b exp=0", out_vld); end
  endtask

  task automatic test_reset_midstream();
    out_rdy = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      a_dat = 8'(i); s_dat = 3'd0; in_vld = 1'b1;
      tick();
    end
    in_vld = 1'b1; a_dat = 8'h77; rst = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL rstm_in_rdy got=%0b exp=1", in_rdy); end
    tick();
    rst = 1'b0; in_vld = 1'b0;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rstm_vld got=%0b exp=0", out_vld); end
    checks++; if (z_dat !== 12'h000) begin failures++; $display("FAIL rstm_z got=%0h exp=0", z_dat); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rstm_ovf got=%0b exp=0", ovf); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rstm_flushed%0d got=%0b exp=0", c, out_vld); end
    end
    a_dat = 8'h05; s_dat = 3'd2; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rstm_new_early got=%0b exp=0", out_vld); end
    tick();
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL rstm_new_vld got=%0b exp=1", out_vld); end
    checks++; if (z_dat !== 12'h014) begin failures++; $display("FAIL rstm_new_z got=%0h exp=14", z_dat); end
    tick();
  endtask

  task automatic test_unsigned();
    logic [7:0]  va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [2:0]  vs [3] = '{3'd4, 3'd5, 3'd7};
    logic [11:0] vz [3] = '{12'hFF0, 12'hFE0, 12'h000};
    logic        vo [3] = '{1'b0, 1'b1, 1'b0};
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_dat = va[i]; s_dat = vs[i]; in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      tick();
      tick();
      checks++; if (out_vld_u !== 1'b1) begin failures++; $display("FAIL uns_vec%0d_vld got=%0b exp=1", i, out_vld_u); end
      checks++; if (z_dat_u !== vz[i]) begin failures++; $display("FAIL uns_vec%0d_z got=%0h exp=%0h", i, z_dat_u, vz[i]); end
      checks++; if (ovf_u !== vo[i]) begin failures++; $display("FAIL uns_vec%0d_ovf got=%0b exp=%0b", i, ovf_u, vo[i]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_unsigned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_l_pipe.md
SHIFT_L_PIPE -- requirements
Module: shift_l_pipe

Interface
- REQ-001: width_a, default 8, data input width in bits; the block SHALL require width_a <= width_z.
- REQ-002: signd_a, default 1, SHALL select the input type: 1 = two's-complement (sign-extend), 0 = unsigned (zero-extend).
- REQ-003: width_s, default 3, shift-amount width in bits; it SHALL also be the pipeline depth.
- REQ-004: width_z, default 12, result width in bits.
- REQ-005: clk  in  1  sole clock; all state SHALL update on the rising edge.
- REQ-006: rst  in  1  reset; it SHALL be synchronous and active-high.
- REQ-007: a_dat  in  width_a  operand.
- REQ-008: s_dat  in  width_s  unsigned left-shift amount.
- REQ-009: in_vld  in  1  a_dat and s_dat are valid.
- REQ-010: in_rdy  out  1  the block can accept an input this cycle.
- REQ-011: z_dat  out  width_z  shifted result.
- REQ-012: ovf  out  1  the result is not exactly representable in width_z bits.
- REQ-013: out_vld  out  1  z_dat and ovf are valid.
- REQ-014: out_rdy  in  1  the consumer accepts the output this cycle.

Function
- REQ-015: An input SHALL be accepted on a rising edge where in_vld=1 and in_rdy=1; an output SHALL be transferred on a rising edge where out_vld=1 and out_rdy=1.
- REQ-016: The operand SHALL be extended to width_z bits (sign-extended if signd_a=1, zero-extended if signd_a=0), shifted left by s_dat with zero fill, and truncated to width_z bits.
- REQ-017: If s_dat >= width_z, z_dat SHALL be 0.
- REQ-018: ovf SHALL be 1 if and only if z_dat, read as signed (signd_a=1) or unsigned (signd_a=0), differs from ext(a_dat) * 2^s_dat; this SHALL include nonzero operands with s_dat >= width_z.
- REQ-019: The block SHALL be a pipeline of width_s register stages; stage k SHALL apply a shift of 2^k when s_dat[k]=1, carrying the remaining shift bits, a valid bit and a sticky ovf bit.
- REQ-020: Latency: for an input accepted at the end of cycle N with no stall, out_vld SHALL be 1 in cycle N+width_s.
- REQ-021: Throughput SHALL be one result per cycle when out_rdy is held at 1.
- REQ-022: Stall condition: stall = out_vld AND NOT out_rdy; in_rdy SHALL equal NOT stall, and this path SHALL be combinational from out_rdy.
- REQ-023: On a stall, every stage register (data, shift, valid, ovf) SHALL hold its value, and z_dat/ovf SHALL remain stable while out_vld=1 and out_rdy=0.
- REQ-024: Bubbles SHALL NOT be collapsed during a stall; the pipeline SHALL advance as a whole.
- REQ-025: Results SHALL leave in acceptance order, with no loss and no duplication.
- REQ-026: An input presented while in_rdy=0 SHALL be ignored, and in_vld SHALL be permitted to drop without penalty.
- REQ-027: When in_vld=0 on an advancing edge, a bubble SHALL enter stage 0, and out_vld SHALL reflect the bubble width_s cycles later.
- REQ-028: Transfer-out and accept-in on the same edge SHALL both take effect.

Reset
- REQ-029: While rst=1 at a rising edge, all stage valid bits SHALL clear, and z_dat, ovf and out_vld SHALL be 0 from the next cycle.
- REQ-030: rst SHALL take priority over the handshake, and data in flight at reset SHALL be discarded without being output.
- REQ-031: While rst=1, in_rdy SHALL be 1 (the pipeline is empty), but no input SHALL be accepted on an edge where rst=1.

Verification (defaults width_a=8, signd_a=1, width_s=3, width_z=12 unless stated)
- REQ-032: Single op: a=0x81 (-127), s=3, out_rdy=1, accepted at end of cycle 0 -> cycle 3 shows out_vld=1, z=0xC08 (-1016), ovf=0; out_vld=0 in cycles 1-2.
- REQ-033: Overflow: a=0x7F, s=7 -> z=0xF80, ovf=1; a=0x81, s=0 -> z=0xF81, ovf=0; a=0x40, s=5 -> z=0x800, ovf=1.
- REQ-034: Streaming: 8 back-to-back inputs with s=0..7 and a=0x01, out_rdy=1 -> 8 consecutive out_vld cycles starting 3 cycles after the first accept, z=0x001, 0x002, ..., 0x080, all ovf=0.
- REQ-035: Backpressure: 3 items in flight, out_rdy=0 for 4 cycles -> in_rdy=0 and z_dat stable throughout; on out_rdy=1 all 3 items emerge in order, none dropped or repeated.
- REQ-036: Reset mid-stream: rst=1 for one cycle with 2 items in flight -> next cycle out_vld=0, z=0, ovf=0; those items never appear; a new input afterwards has normal 3-cycle latency.
- REQ-037: Unsigned instance (signd_a=0): a=0xFF, s=4 -> z=0xFF0, ovf=0; a=0xFF, s=5 -> z=0xFE0, ovf=1; a=0x00, s=7 -> z=0x000, ovf=0.
